// File: rtl/axi2mem_b_ctrl.sv
// rtl/axi2mem_b_ctrl.sv - in-order write-response controller for the axi2mem slave
module axi2mem_b_ctrl #(
  parameter int ID_WIDTH        = 4,
  parameter int USER_WIDTH      = 6,
  parameter int MAX_OUTSTANDING = 4,
  localparam int CW             = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  aw_push_i,
  input  logic [ID_WIDTH-1:0]   aw_id_i,
  input  logic [USER_WIDTH-1:0] aw_user_i,
  output logic                  aw_ready_o,
  input  logic                  beat_done_i,
  input  logic                  beat_last_i,
  input  logic                  beat_err_i,
  output logic                  b_valid_o,
  output logic [1:0]            b_resp_o,
  output logic [ID_WIDTH-1:0]   b_id_o,
  output logic [USER_WIDTH-1:0] b_user_o,
  input  logic                  b_ready_i,
  output logic [CW-1:0]         outstanding_o,
  output logic                  proto_err_o
);

  localparam int IW = CW - 1;
  localparam logic [CW-1:0] DEPTH = CW'(MAX_OUTSTANDING);

  logic [CW-1:0]         alloc_ptr, beat_ptr, resp_ptr;
  logic [ID_WIDTH-1:0]   id_mem   [MAX_OUTSTANDING];
  logic [USER_WIDTH-1:0] user_mem [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] err_mem;
  logic                  proto_err_q;

  logic [IW-1:0] alloc_idx, beat_idx, resp_idx;
  logic          push_ok, beat_ok, b_hs;

  assign alloc_idx = alloc_ptr[IW-1:0];
  assign beat_idx  = beat_ptr[IW-1:0];
  assign resp_idx  = resp_ptr[IW-1:0];

  // Everything below looks only at registered pointers, so a B handshake
  // cannot free a slot for a push in the same cycle.
  assign outstanding_o = alloc_ptr - resp_ptr;
  assign aw_ready_o    = outstanding_o < DEPTH;
  assign b_valid_o     = resp_ptr != beat_ptr;
  assign b_resp_o      = (b_valid_o && err_mem[resp_idx]) ? 2'b10 : 2'b00;
  assign b_id_o        = b_valid_o ? id_mem[resp_idx]   : '0;
  assign b_user_o      = b_valid_o ? user_mem[resp_idx] : '0;
  assign proto_err_o   = proto_err_q;

  assign push_ok = aw_push_i && aw_ready_o;
  assign beat_ok = beat_done_i && (beat_ptr != alloc_ptr);
  assign b_hs    = b_valid_o && b_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      alloc_ptr   <= '0;
      beat_ptr    <= '0;
      resp_ptr    <= '0;
      err_mem     <= '0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        id_mem[i]   <= '0;
        user_mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        id_mem[alloc_idx]   <= aw_id_i;
        user_mem[alloc_idx] <= aw_user_i;
        err_mem[alloc_idx]  <= 1'b0;
        alloc_ptr           <= alloc_ptr + 1'b1;
      end
      // beat_idx never aliases alloc_idx when a push is accepted
      if (beat_ok) begin
        err_mem[beat_idx] <= err_mem[beat_idx] | beat_err_i;
        if (beat_last_i) beat_ptr <= beat_ptr + 1'b1;
      end
      if (b_hs) resp_ptr <= resp_ptr + 1'b1;
      if ((aw_push_i && !aw_ready_o) || (beat_done_i && !beat_ok))
        proto_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi2mem_b_ctrl.sv
// tb/tb_axi2mem_b_ctrl.sv - directed plus random bench for axi2mem_b_ctrl against a queue model
module tb_axi2mem_b_ctrl;
  localparam int MAXO = 4;
  localparam int CW = $clog2(MAXO) + 1;

  logic       clk = 0;
  logic       rst_n = 0;
  logic       aw_push = 0, beat_done = 0, beat_last = 0, beat_err = 0, b_ready = 0;
  logic [3:0] aw_id = 0;
  logic [5:0] aw_user = 0;
  logic       aw_ready, b_valid, proto_err;
  logic [1:0] b_resp;
  logic [3:0] b_id;
  logic [5:0] b_user;
  logic [CW-1:0] outstanding;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] id;
    logic [5:0] user;
    bit         err;
    bit         done;
  } ent_t;
  ent_t q[$];
  bit   m_proto = 0;

  axi2mem_b_ctrl #(.ID_WIDTH(4), .USER_WIDTH(6), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .aw_push_i(aw_push), .aw_id_i(aw_id), .aw_user_i(aw_user), .aw_ready_o(aw_ready),
    .beat_done_i(beat_done), .beat_last_i(beat_last), .beat_err_i(beat_err),
    .b_valid_o(b_valid), .b_resp_o(b_resp), .b_id_o(b_id), .b_user_o(b_user),
    .b_ready_i(b_ready), .outstanding_o(outstanding), .proto_err_o(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model transition from pre-edge state and the inputs held across the edge
  task automatic model_step();
    bit hs;
    int tgt;
    bit can_push;
    hs = (q.size() > 0) && q[0].done && b_ready;
    can_push = q.size() < MAXO;
    tgt = -1;
    foreach (q[i]) if (!q[i].done && tgt < 0) tgt = i;
    if (!rst_n) begin
      q.delete();
      m_proto = 0;
      return;
    end
    if (beat_done) begin
      if (tgt < 0) m_proto = 1;
      else begin
        q[tgt].err = q[tgt].err | beat_err;
        if (beat_last) q[tgt].done = 1;
      end
    end
    if (aw_push) begin
      if (can_push) q.push_back('{id: aw_id, user: aw_user, err: 0, done: 0});
      else m_proto = 1;
    end
    if (hs) void'(q.pop_front());
  endtask

  task automatic check_all();
    bit v;
    v = (q.size() > 0) && q[0].done;
    chk("aw_ready", 32'(aw_ready), 32'(q.size() < MAXO));
    chk("b_valid", 32'(b_valid), 32'(v));
    chk("b_resp", 32'(b_resp), v ? (q[0].err ? 32'd2 : 32'd0) : 32'd0);
    chk("b_id", 32'(b_id), v ? 32'(q[0].id) : 32'd0);
    chk("b_user", 32'(b_user), v ? 32'(q[0].user) : 32'd0);
    chk("outstanding", 32'(outstanding), 32'(q.size()));
    chk("proto_err", 32'(proto_err), 32'(m_proto));
  endtask

  task automatic cyc(input bit p, input logic [3:0] id, input logic [5:0] user,
                     input bit d, input bit l, input bit e, input bit r);
    aw_push = p; aw_id = id; aw_user = user;
    beat_done = d; beat_last = l; beat_err = e; b_ready = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    aw_push = 0; beat_done = 0; beat_last = 0; beat_err = 0;
    check_all();
  endtask

  initial begin
    // reset
    rst_n = 0;
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1;
    chk("rst_outstanding", 32'(outstanding), 0);

    // single burst: push N, last beat N+1, B at N+2
    cyc(1, 3, 5, 0, 0, 0, 1);
    chk("single_out1", 32'(outstanding), 1);
    chk("single_noB", 32'(b_valid), 0);
    cyc(0, 0, 0, 1, 1, 0, 1);
    chk("single_valid", 32'(b_valid), 1);
    chk("single_id", 32'(b_id), 3);
    chk("single_user", 32'(b_user), 5);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("single_out0", 32'(outstanding), 0);

    // error burst then a clean burst
    cyc(1, 1, 9, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 1, 0);
    cyc(1, 2, 4, 1, 1, 0, 0);
    chk("err_resp", 32'(b_resp), 2);
    chk("err_id", 32'(b_id), 1);
    cyc(0, 0, 0, 1, 1, 0, 1);
    chk("clean_id", 32'(b_id), 2);
    chk("clean_resp", 32'(b_resp), 0);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // fill with backpressure
    cyc(1, 0, 10, 0, 0, 0, 0);
    for (int i = 1; i < 4; i++) cyc(1, 4'(i), 6'(10 + i), 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 0);
    chk("full_ready", 32'(aw_ready), 0);
    chk("full_out", 32'(outstanding), 4);
    cyc(1, 9, 9, 0, 0, 0, 0);
    chk("full_proto", 32'(proto_err), 1);
    chk("full_hold", 32'(b_id), 0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_id", 32'(b_id), 32'(i));
      cyc(0, 0, 0, 0, 0, 0, 1);
      if (i == 0) chk("drain_ready", 32'(aw_ready), 1);
    end

    // simultaneous push / last beat / handshake
    cyc(1, 5, 1, 0, 0, 0, 0);
    cyc(1, 6, 2, 1, 1, 0, 0);
    cyc(1, 7, 3, 1, 1, 0, 1);
    chk("simul_out", 32'(outstanding), 2);
    chk("simul_id", 32'(b_id), 6);
    cyc(0, 0, 0, 1, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // wrap-around
    for (int i = 0; i < 10; i++) begin
      cyc(1, 4'(i), 6'(i), 0, 0, 0, 1);
      cyc(0, 0, 0, 1, 1, 0, 1);
      chk("wrap_id", 32'(b_id), 32'(i));
      cyc(0, 0, 0, 0, 0, 0, 1);
    end

    // orphan beat, then reset with pending responses
    rst_n = 0; cyc(0, 0, 0, 0, 0, 0, 0); rst_n = 1;
    cyc(0, 0, 0, 1, 1, 0, 1);
    chk("orphan_proto", 32'(proto_err), 1);
    chk("orphan_noB", 32'(b_valid), 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    cyc(1, 2, 2, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 0);
    chk("pend_out", 32'(outstanding), 2);
    rst_n = 0; cyc(0, 0, 0, 0, 0, 0, 0); rst_n = 1;
    chk("rst_valid", 32'(b_valid), 0);
    chk("rst_out", 32'(outstanding), 0);
    chk("rst_proto", 32'(proto_err), 0);
    chk("rst_ready", 32'(aw_ready), 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      cyc($urandom_range(0, 2) == 0, 4'($urandom), 6'($urandom),
          $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
          $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
    end
    rst_n = 1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
